// File: rtl/negedge_detector.sv
// Per-bit falling-edge detector with optional synchronizer and debounce filter.
// Each bit runs sync -> filter -> detect independently; e is a registered one-cycle pulse.
module negedge_detector #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 0,
    parameter int FILTER_LEN  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e
);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] p;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [WIDTH-1:0] chain [SYNC_STAGES];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        chain[k] <= '0;
                    end
                end else begin
                    chain[0] <= d;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        chain[k] <= chain[k-1];
                    end
                end
            end

            assign s = chain[SYNC_STAGES-1];
        end else begin : g_nosync
            assign s = d;
        end
    endgenerate

    // The filtered level only follows s after FILTER_LEN consecutive cycles of disagreement;
    // the counter tops out at FILTER_LEN-1 and clears on the flip, so it cannot wrap.
    generate
        if (FILTER_LEN > 0) begin : g_filter
            localparam int CW = $clog2(FILTER_LEN + 1);
            localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                logic [CW-1:0] cnt;
                logic          level;

                always_ff @(posedge clk) begin
                    if (reset) begin
                        cnt   <= '0;
                        level <= 1'b0;
                    end else if (s[i] == level) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        level <= s[i];
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                assign f[i] = level;
            end
        end else begin : g_nofilter
            assign f = s;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            p <= '0;
            e <= '0;
        end else begin
            e <= p & ~f;
            p <= f;
        end
    end

endmodule

// File: tb/tb_negedge_detector.sv
// Scoreboard bench for negedge_detector: four configurations, directed vectors with
// hand-computed expected pulses queued by the stimulus and checked by an independent monitor.
module tb_negedge_detector;

    logic       clk;
    logic       rst0, rst1, rst2, rst3;
    logic       d0, d1, d2;
    logic [3:0] d3;
    logic       e0, e1, e2;
    logic [3:0] e3;

    logic [3:0] q0 [$];
    logic [3:0] q1 [$];
    logic [3:0] q2 [$];
    logic [3:0] q3 [$];

    int checks = 0;
    int errors = 0;

    negedge_detector #(.WIDTH(1), .SYNC_STAGES(0), .FILTER_LEN(0)) u_basic (
        .clk(clk), .reset(rst0), .d(d0), .e(e0)
    );

    negedge_detector #(.WIDTH(1), .SYNC_STAGES(2), .FILTER_LEN(0)) u_sync (
        .clk(clk), .reset(rst1), .d(d1), .e(e1)
    );

    negedge_detector #(.WIDTH(1), .SYNC_STAGES(0), .FILTER_LEN(3)) u_filt (
        .clk(clk), .reset(rst2), .d(d2), .e(e2)
    );

    negedge_detector #(.WIDTH(4), .SYNC_STAGES(0), .FILTER_LEN(0)) u_wide (
        .clk(clk), .reset(rst3), .d(d3), .e(e3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change mid-low-phase; the expected e after the coming rising edge is queued.
    task automatic applyStimulus(input int dut, input logic r, input logic [3:0] dv,
                                 input logic [3:0] expv);
        @(negedge clk);
        #2;
        case (dut)
            0: begin rst0 = r; d0 = dv[0]; q0.push_back(expv); end
            1: begin rst1 = r; d1 = dv[0]; q1.push_back(expv); end
            2: begin rst2 = r; d2 = dv[0]; q2.push_back(expv); end
            default: begin rst3 = r; d3 = dv; q3.push_back(expv); end
        endcase
    endtask

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t: e=%b expected %b", name, $time, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() != 0) checkOutput("basic_e", {3'b000, e0}, q0.pop_front());
        if (q1.size() != 0) checkOutput("sync_e",  {3'b000, e1}, q1.pop_front());
        if (q2.size() != 0) checkOutput("filt_e",  {3'b000, e2}, q2.pop_front());
        if (q3.size() != 0) checkOutput("wide_e",  e3,           q3.pop_front());
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        d0 = 1'b0; d1 = 1'b0; d2 = 1'b0; d3 = 4'h0;

        // Basic fall: two pulses, none on rises
        applyStimulus(0, 1, 4'h0, 4'h0);
        applyStimulus(0, 1, 4'h0, 4'h0);
        applyStimulus(0, 0, 4'h0, 4'h0);
        applyStimulus(0, 0, 4'h1, 4'h0);
        applyStimulus(0, 0, 4'h0, 4'h1);
        applyStimulus(0, 0, 4'h0, 4'h0);
        applyStimulus(0, 0, 4'h1, 4'h0);
        applyStimulus(0, 0, 4'h1, 4'h0);
        applyStimulus(0, 0, 4'h0, 4'h1);
        applyStimulus(0, 0, 4'h0, 4'h0);

        // Reset behaviour: high across release, reset mid-pulse, fall hidden by reset
        applyStimulus(0, 1, 4'h1, 4'h0);
        applyStimulus(0, 1, 4'h1, 4'h0);
        applyStimulus(0, 0, 4'h1, 4'h0);
        applyStimulus(0, 0, 4'h1, 4'h0);
        applyStimulus(0, 0, 4'h0, 4'h1);
        applyStimulus(0, 1, 4'h0, 4'h0);
        applyStimulus(0, 0, 4'h1, 4'h0);
        applyStimulus(0, 1, 4'h0, 4'h0);
        applyStimulus(0, 0, 4'h0, 4'h0);
        applyStimulus(0, 1, 4'h0, 4'h0);
        applyStimulus(0, 1, 4'h0, 4'h0);
        applyStimulus(0, 0, 4'h0, 4'h0);
        applyStimulus(0, 0, 4'h0, 4'h0);
        applyStimulus(0, 0, 4'h1, 4'h0);
        applyStimulus(0, 0, 4'h0, 4'h1);

        // Rising only with long high, then minimum pulse spacing
        for (int k = 0; k < 6; k++) applyStimulus(0, 0, 4'h1, 4'h0);
        applyStimulus(0, 0, 4'h0, 4'h1);
        applyStimulus(0, 0, 4'h1, 4'h0);
        applyStimulus(0, 0, 4'h0, 4'h1);
        applyStimulus(0, 0, 4'h0, 4'h0);

        // Synchronizer: pulse two cycles later than without it
        applyStimulus(1, 1, 4'h0, 4'h0);
        applyStimulus(1, 1, 4'h0, 4'h0);
        for (int k = 0; k < 3; k++) applyStimulus(1, 0, 4'h1, 4'h0);
        applyStimulus(1, 0, 4'h0, 4'h0);
        applyStimulus(1, 0, 4'h0, 4'h0);
        applyStimulus(1, 0, 4'h0, 4'h1);
        applyStimulus(1, 0, 4'h0, 4'h0);
        applyStimulus(1, 0, 4'h0, 4'h0);

        // Debounce: 2-cycle glitch rejected, sustained low pulses 3 cycles later
        applyStimulus(2, 1, 4'h0, 4'h0);
        applyStimulus(2, 1, 4'h0, 4'h0);
        for (int k = 0; k < 6; k++) applyStimulus(2, 0, 4'h1, 4'h0);
        applyStimulus(2, 0, 4'h0, 4'h0);
        applyStimulus(2, 0, 4'h0, 4'h0);
        applyStimulus(2, 0, 4'h1, 4'h0);
        applyStimulus(2, 0, 4'h1, 4'h0);
        applyStimulus(2, 0, 4'h0, 4'h0);
        applyStimulus(2, 0, 4'h0, 4'h0);
        applyStimulus(2, 0, 4'h0, 4'h0);
        applyStimulus(2, 0, 4'h0, 4'h1);
        applyStimulus(2, 0, 4'h0, 4'h0);
        applyStimulus(2, 0, 4'h0, 4'h0);

        // Multi-bit independence
        applyStimulus(3, 1, 4'hF, 4'h0);
        applyStimulus(3, 1, 4'hF, 4'h0);
        applyStimulus(3, 0, 4'hF, 4'h0);
        applyStimulus(3, 0, 4'hF, 4'h0);
        applyStimulus(3, 0, 4'hA, 4'h5);
        applyStimulus(3, 0, 4'hA, 4'h0);
        applyStimulus(3, 0, 4'h2, 4'h8);
        applyStimulus(3, 0, 4'h2, 4'h0);

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ((q0.size() + q1.size() + q2.size() + q3.size()) != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0",
                     q0.size() + q1.size() + q2.size() + q3.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
